fp_mul_seq: RTL

FP_MUL_SEQ -- requirements
Module: fp_mul_seq

---
 rtl/fp_mul_seq.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/fp_mul_seq.sv
// fp_mul_seq: sequential IEEE-754 single-precision multiplier.
// The 24x24 significand product is built by a radix-2 shift-add loop of one
// step per cycle, then normalised and rounded in a single NORM cycle.
//
// Handshake: an operand pair transfers on a rising edge where in_valid and
// in_ready are both high; a result transfers on a rising edge where out_valid
// and out_ready are both high. out_valid, res and the flags stay stable
// until that transfer, and in_valid is ignored whenever in_ready is low.
//
// Special operands (exponent 255, or a zero significand) are classified from
// the registered operands in the first MUL cycle. With EARLY_SPECIAL set,
// that cycle exits straight to DONE without running any multiply steps.
module fp_mul_seq #(
  parameter int EARLY_SPECIAL = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] res,
  output logic        exception,
  output logic        overflow,
  output logic        underflow,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nx;

  logic        sign_r;
  logic [7:0]  ea_r;
  logic [7:0]  eb_r;
  logic [23:0] sa_r;
  logic [23:0] sb_r;
  logic [47:0] acc;
  logic [4:0]  cnt;

  logic        exc_c;
  logic        zero_op_c;
  logic        special_c;
  logic        norm_c;
  logic        zero_c;
  logic        ovf_c;
  logic        unf_c;
  logic [46:0] pn_c;
  logic [22:0] mant_c;
  logic [8:0]  e_c;
  logic [31:0] res_c;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Operand classification from the registered exponents and significands.
  assign exc_c     = (&ea_r) | (&eb_r);
  assign zero_op_c = (sa_r == 24'd0) | (sb_r == 24'd0);
  assign special_c = (EARLY_SPECIAL != 0) && (exc_c || zero_op_c);

  // Normalise, round and pick the packed result from the accumulator.
  // On the early special exit the accumulator is still clear, so zero_c is
  // set and the same selection yields the signed zero or exception result.
  always_comb begin
    norm_c = acc[47];
    pn_c   = norm_c ? acc[46:0] : {acc[45:0], 1'b0};
    mant_c = pn_c[46:24] + {22'd0, pn_c[23] & (|pn_c[22:0])};
    e_c    = {1'b0, ea_r} + {1'b0, eb_r} - 9'd127 + {8'd0, norm_c};
    zero_c = (acc == 48'd0);
    ovf_c  = e_c[8] & ~e_c[7] & ~zero_c;
    unf_c  = e_c[8] & e_c[7] & ~zero_c;
    if (exc_c)       res_c = 32'h0000_0000;
    else if (zero_c) res_c = {sign_r, 31'd0};
    else if (ovf_c)  res_c = {sign_r, 8'hFF, 23'd0};
    else if (unf_c)  res_c = {sign_r, 31'd0};
    else             res_c = {sign_r, e_c[7:0], mant_c};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid) state_nx = MUL;
      MUL: begin
        if ((cnt == 5'd0) && special_c) state_nx = DONE;
        else if (cnt == 5'd23)          state_nx = NORM;
      end
      NORM:    state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: operand capture, shift-add steps and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_r    <= 1'b0;
      ea_r      <= 8'd0;
      eb_r      <= 8'd0;
      sa_r      <= 24'd0;
      sb_r      <= 24'd0;
      acc       <= 48'd0;
      cnt       <= 5'd0;
      res       <= 32'd0;
      exception <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sign_r <= a[31] ^ b[31];
            ea_r   <= a[30:23];
            eb_r   <= b[30:23];
            sa_r   <= {|a[30:23], a[22:0]};
            sb_r   <= {|b[30:23], b[22:0]};
            acc    <= 48'd0;
            cnt    <= 5'd0;
          end
        end
        MUL: begin
          if ((cnt == 5'd0) && special_c) begin
            res       <= res_c;
            exception <= exc_c;
            overflow  <= ovf_c;
            underflow <= unf_c;
          end else begin
            if (sb_r[cnt]) acc <= acc + ({24'd0, sa_r} << cnt);
            cnt <= cnt + 5'd1;
          end
        end
        NORM: begin
          res       <= res_c;
          exception <= exc_c;
          overflow  <= ovf_c;
          underflow <= unf_c;
        end
        DONE:    ;
        default: ;
      endcase
    end
  end

endmodule
